// File: rtl/svc_rr_mux.sv
// svc_rr_mux: N-input valid/ready round-robin stream mux, registered output.
// Optional packet lock: define SVC_RR_MUX_PKT_LOCK_EN.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    per-input handshake (N bits each)
//   in_data              N*WIDTH, input i at [i*WIDTH +: WIDTH]
//   in_last              per-input end-of-packet flag
//   out_valid/out_ready  output handshake
//   out_data, out_last   registered output beat
//   out_grant            one-hot source of the current output beat
module svc_rr_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [N-1:0]       out_grant,
  input  logic               out_ready
);

  localparam int IW = $clog2(N);

  logic             accept;
  logic             take;
  logic             adv;
  logic [N-1:0]     grant;
  logic [N-1:0]     rr_gnt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;

  // First requester after p, wrapping N-1 -> 0.
  function automatic logic [N-1:0] rr_pick(
    input logic [N-1:0]  req,
    input logic [IW-1:0] p
  );
    logic [N-1:0]  g;
    logic          hit;
    logic [IW-1:0] j;
    g   = '0;
    hit = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(p) + k) % N);
      if (!hit && req[j]) begin
        g[j] = 1'b1;
        hit  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [IW-1:0] oh2idx(
    input logic [N-1:0] oh
  );
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) r = r | IW'(i);
    end
    return r;
  endfunction

  assign accept   = !out_valid || out_ready;
  assign rr_gnt   = rr_pick(in_valid, ptr);
  assign in_ready = grant & {N{accept}};
  assign take     = |in_ready;
  assign win      = oh2idx(grant);

  always_comb begin
    mux_data = '0;
    mux_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      mux_data = mux_data
               | ({WIDTH{grant[i]}} & in_data[i*WIDTH +: WIDTH]);
      mux_last = mux_last | (grant[i] & in_last[i]);
    end
  end

`ifdef SVC_RR_MUX_PKT_LOCK_EN
  logic         lock;
  logic [N-1:0] lock_gnt;

  // While locked, only the packet owner may be granted; a stalled
  // owner blocks everyone rather than letting another input interleave.
  assign grant = lock ? (in_valid & lock_gnt) : rr_gnt;
  // Fairness rotates per packet, not per beat.
  assign adv   = mux_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      lock_gnt <= '0;
    end else if (take) begin
      lock     <= !mux_last;
      lock_gnt <= grant;
    end
  end
`else
  assign grant = rr_gnt;
  assign adv   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_grant <= '0;
      ptr       <= IW'(N - 1);
    end else if (accept) begin
      out_valid <= take;
      if (take) begin
        out_data  <= mux_data;
        out_last  <= mux_last;
        out_grant <= grant;
        if (adv) ptr <= win;
      end
    end
  end

endmodule
